// File: rtl/serial_sub_8_bit.sv
// serial_sub_8_bit: bit-serial unsigned subtractor.
// Computes diff = x - y - borrow_in (mod 2^WIDTH) one bit per clock, LSB
// first, through a single full-subtractor cell. It produces borrow_out and
// pulses done for one cycle when the result is loaded.
// Optional feature: define SERIAL_SUB_OVERFLOW_EN to add a registered
// signed-overflow output.
module serial_sub_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             borrow_out,
  output logic             overflow
`else
  output logic             borrow_out
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             bw;
  logic [CNT_W-1:0] cnt;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             x_msb;
  logic             y_msb;
`endif

  // One-bit full subtractor: returns {borrow_next, difference_bit}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bw_i);
    logic d;
    logic bn;
    d  = a ^ b ^ bw_i;
    bn = (~a & b) | (~(a ^ b) & bw_i);
    return {bn, d};
  endfunction

  logic             d_bit;
  logic             bw_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  assign {bw_next, d_bit} = full_sub(a_sr[0], b_sr[0], bw);
  // Difference bits enter at the MSB so the LSB computed first ends up at bit 0.
  assign res_next = {d_bit, res_sr[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Control FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      cnt        <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      bw         <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      overflow   <= 1'b0;
      x_msb      <= 1'b0;
      y_msb      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= x;
            b_sr   <= y;
            bw     <= borrow_in;
            res_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
            x_msb  <= x[WIDTH-1];
            y_msb  <= y[WIDTH-1];
`endif
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately not looked at here; an operation in flight
          // always runs to completion.
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          bw     <= bw_next;
          res_sr <= res_next;
          if (last_bit) begin
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= res_next;
            borrow_out <= bw_next;
            state      <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow   <= (x_msb != y_msb) && (d_bit != x_msb);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_8_bit.sv
// Scoreboard testbench for serial_sub_8_bit. The driver predicts each
// accepted subtraction with plain integer arithmetic and queues it. A
// separate monitor compares whenever done is seen, and checks busy and
// output stability every cycle.
module tb_serial_sub_8_bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic       borrow_in = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       overflow;
`endif

  serial_sub_8_bit #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x          (x),
    .y          (y),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .borrow_out (borrow_out),
    .overflow   (overflow)
`else
    .borrow_out (borrow_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int b;
    int o;
    int e;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  int   next_ok = 0;
  int   last_acc = -100;
  int   hold_d = 0;
  int   hold_b = 0;
  int   hold_o = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; the model decides whether the DUT accepts it.
  task automatic drive(input logic s, input logic [7:0] xa, input logic [7:0] ya,
                       input logic b);
    exp_t t;
    int   r;
    int   sr;
    @(negedge clk);
    start     = s;
    x         = xa;
    y         = ya;
    borrow_in = b;
    if (s && (edge_cnt + 1) >= next_ok) begin
      r   = int'(xa) - int'(ya) - int'(b);
      sr  = int'($signed(xa)) - int'($signed(ya)) - int'(b);
      t.d = (r + 256) % 256;
      t.b = (r < 0) ? 1 : 0;
      t.o = (sr < -128 || sr > 127) ? 1 : 0;
      t.e = edge_cnt + 1 + 8;
      q.push_back(t);
      last_acc = edge_cnt + 1;
      next_ok  = edge_cnt + 1 + 9;
    end
  endtask

  // Monitor: compare on done, and check busy and output hold every cycle.
  always @(negedge clk) begin
    exp_t t;
    if (rst_n) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          t = q.pop_front();
          chk("done_edge", edge_cnt, t.e);
          hold_d = t.d;
          hold_b = t.b;
          hold_o = t.o;
        end
      end
      chk("diff", int'(diff), hold_d);
      chk("borrow_out", int'(borrow_out), hold_b);
`ifdef SERIAL_SUB_OVERFLOW_EN
      chk("overflow", int'(overflow), hold_o);
`endif
      chk("busy", int'(busy), (edge_cnt >= last_acc && edge_cnt < last_acc + 8) ? 1 : 0);
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_diff"}, int'(diff), 0);
    chk({tag, "_borrow"}, int'(borrow_out), 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk({tag, "_overflow"}, int'(overflow), 0);
`endif
  endtask

  task automatic clear_model();
    q.delete();
    hold_d   = 0;
    hold_b   = 0;
    hold_o   = 0;
    last_acc = -100;
    next_ok  = 0;
  endtask

  initial begin
    int waited;
    // Asynchronous reset at start-up, checked without a clock edge.
    #3 rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    clear_model();
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // 150-100, then 34-40 back-to-back with start held through DONE.
    drive(1, 8'd150, 8'd100, 1'b0);
    repeat (9) drive(1, 8'd34, 8'd40, 1'b0);
    drive(0, 8'd0, 8'd0, 1'b0);
    repeat (10) drive(0, 8'd0, 8'd0, 1'b0);

    // Borrow-in boundaries.
    drive(1, 8'd0, 8'd0, 1'b1);
    repeat (10) drive(0, 8'd0, 8'd0, 1'b0);
    drive(1, 8'd255, 8'd255, 1'b1);
    repeat (10) drive(0, 8'd0, 8'd0, 1'b0);

    // start pulsed during RUN cycle 3 must be ignored.
    drive(1, 8'd200, 8'd55, 1'b0);
    repeat (2) drive(0, 8'd0, 8'd0, 1'b0);
    drive(1, 8'd9, 8'd9, 1'b0);
    repeat (10) drive(0, 8'd0, 8'd0, 1'b0);

    // Signed-overflow corner cases (also plain unsigned checks without the option).
    drive(1, 8'd128, 8'd1, 1'b0);
    repeat (10) drive(0, 8'd0, 8'd0, 1'b0);
    drive(1, 8'd5, 8'd3, 1'b0);
    repeat (10) drive(0, 8'd0, 8'd0, 1'b0);

    // Reset during RUN cycle 4: outputs clear at once and no done follows.
    drive(1, 8'd77, 8'd20, 1'b0);
    repeat (3) drive(0, 8'd0, 8'd0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    start = 1'b0;
    #1 check_zero_outputs("midrun_reset");
    clear_model();
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(1, 8'd10, 8'd3, 1'b0);
    repeat (10) drive(0, 8'd0, 8'd0, 1'b0);

    // Randomized traffic with random start patterns.
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    drive(0, 8'd0, 8'd0, 1'b0);

    // Bounded wait for any outstanding result.
    waited = 0;
    while (q.size() != 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sub_8_bit.md
SERIAL_SUB_8_BIT -- requirements
Module: serial_sub_8_bit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; WIDTH=8 is the only verified value.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-005 SHALL have port x  input  WIDTH  minuend (unsigned); captured when start is accepted.
REQ-006 SHALL have port y  input  WIDTH  subtrahend (unsigned); captured when start is accepted.
REQ-007 SHALL have port borrow_in  input  1  initial borrow; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while in state RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port diff  output  WIDTH  registered result, x - y - borrow_in mod 2^WIDTH.
REQ-011 SHALL have port borrow_out  output  1  registered final borrow; 1 iff x < y + borrow_in (unsigned).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; encoding free.
REQ-013 SHALL accept start only in IDLE or DONE: capture x, y, borrow_in into shift/borrow registers, clear the bit counter, go to RUN.
REQ-014 SHALL ignore start while in RUN; captured operands and progress are unaffected.
REQ-015 SHALL in RUN process one bit per cycle, LSB first, with a 1-bit full subtractor (d = a^b^bw; bw_next = (~a&b)|(~(a^b)&bw)), shifting d into a result shift register.
REQ-016 SHALL leave RUN after exactly WIDTH cycles; the counter wraps to 0 and does not advance outside RUN.
REQ-017 SHALL on the RUN->DONE edge load diff and borrow_out from the shift register and final borrow; start accepted at edge k gives done high for the cycle after edge k+WIDTH.
REQ-018 SHALL assert done only in DONE, for exactly one cycle; DONE goes to IDLE when start is low, else to RUN (back-to-back, no idle cycle).
REQ-019 SHALL hold diff and borrow_out stable from the DONE load until the next DONE load; they do not change during RUN.
REQ-020 SHALL keep busy low in IDLE and DONE and high in every RUN cycle.

Reset
REQ-021 SHALL on rst_n low immediately (no clk needed) force state IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, internal shift/borrow registers=0.
REQ-022 SHALL abort an in-progress RUN on reset with no done pulse; the first start after rst_n rises is accepted normally.

Configuration
REQ-023 SHALL, when macro SERIAL_SUB_OVERFLOW_EN is defined, add output port overflow (1 bit, reset 0), loaded with diff on the RUN->DONE edge = signed two's-complement overflow of x - y - borrow_in (x[MSB]!=y[MSB] and diff[MSB]!=x[MSB]).
REQ-024 SHALL, when SERIAL_SUB_OVERFLOW_EN is undefined, have no overflow port and no overflow logic; all other behaviour identical.

Verification
REQ-025 SHALL cover: x=150,y=100,borrow_in=0 -> done 8 cycles after accept, diff=50, borrow_out=0; then x=34,y=40,borrow_in=0 back-to-back (start held in DONE) -> diff=250, borrow_out=1.
REQ-026 SHALL cover boundary: x=0,y=0,borrow_in=1 -> diff=255, borrow_out=1; x=255,y=255,borrow_in=1 -> diff=255, borrow_out=1.
REQ-027 SHALL cover: start pulsed with x=9,y=9 at RUN cycle 3 of a x=200,y=55 operation -> ignored; single done, diff=145, borrow_out=0.
REQ-028 SHALL cover: rst_n low at RUN cycle 4 -> outputs 0 asynchronously, no done; next start x=10,y=3 -> diff=7, borrow_out=0.
REQ-029 SHALL cover with SERIAL_SUB_OVERFLOW_EN: x=128,y=1,borrow_in=0 -> diff=127, borrow_out=0, overflow=1; x=5,y=3 -> overflow=0.
